// File: rtl/seg_adder_pkg.sv
// Shared types and default sizing for the segmented (chunk-serial) adder.
// Holds the controller state encoding and default operand/chunk widths.
// No logic lives here; the top and its chunk adder import it.
package seg_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SEG_N_DEF = 32;
  localparam int SEG_W_DEF = 8;

endpackage

// File: rtl/seg_adder_chunk_add.sv
// Combinational W-bit ripple-carry adder slice used once per RUN cycle.
// Latency: zero cycles (purely combinational).
// Backpressure: none; the caller registers sum and carry as needed.
module chunk_add #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_c,
  output logic [W-1:0] o_sum,
  output logic         o_c,
  output logic         o_c_msb
);

  logic [W-1:0] w_p;
  logic [W-1:0] w_g;
  logic [W:0]   w_c;

  assign w_p = i_a ^ i_b;
  assign w_g = i_a & i_b;

  // Ripple the carry from bit 0 upward: c[k+1] = g[k] | p[k] & c[k].
  always_comb begin
    w_c    = '0;
    w_c[0] = i_c;
    for (int k = 0; k < W; k++) begin
      w_c[k+1] = w_g[k] | (w_p[k] & w_c[k]);
    end
  end

  assign o_sum   = w_p ^ w_c[W-1:0];
  assign o_c     = w_c[W];
  // Carry into the slice MSB; only meaningful for the top chunk's overflow.
  assign o_c_msb = w_c[W-1];

endmodule

// File: rtl/seg_adder.sv
// Chunk-serial N-bit add/subtract: W bits per cycle over K=N/W cycles.
// Latency: out_valid rises K edges after the accepting edge; one result per K+2 cycles.
// Backpressure: result held in DONE until out_ready; operands accepted only in IDLE.
// Build option: define SEG_ADDER_OVF_EN to build the signed-overflow flag; otherwise ovf is tied 0.
module seg_adder
  import seg_adder_pkg::*;
#(
  parameter int N = SEG_N_DEF,
  parameter int W = SEG_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] s,
  output logic         c_out,
  output logic         ovf
);

  localparam int  K      = (W >= 1) ? (N / W) : 1;
  localparam int  IW     = (K > 1) ? $clog2(K) : 1;
  localparam bit  CFG_OK = (W >= 1) && (W <= N) && ((N % ((W >= 1) ? W : 1)) == 0);

  // Refuse to elaborate a width combination that does not split evenly.
  generate
    if (!CFG_OK) begin : g_bad_cfg
      $error("seg_adder: require 1 <= W <= N and N %% W == 0");
    end
  endgenerate

  state_t        r_state;
  logic [N-1:0]  r_a;
  logic [N-1:0]  r_b;
  logic          r_carry;
  logic [IW-1:0] r_idx;
  logic [N-1:0]  r_s;
  logic          r_c_out;

  logic [W-1:0]  w_a_chunk;
  logic [W-1:0]  w_b_chunk;
  logic [W-1:0]  w_sum;
  logic          w_c;
  logic          w_last;

  assign w_a_chunk = r_a[r_idx*W +: W];
  assign w_b_chunk = r_b[r_idx*W +: W];
  assign w_last    = (r_idx == IW'(K - 1));

`ifdef SEG_ADDER_OVF_EN
  logic w_c_msb;
  logic r_ovf;
`else
  logic w_unused_c_msb;
`endif

  chunk_add #(.W(W)) u_chunk_add (
    .i_a     (w_a_chunk),
    .i_b     (w_b_chunk),
    .i_c     (r_carry),
    .o_sum   (w_sum),
    .o_c     (w_c),
`ifdef SEG_ADDER_OVF_EN
    .o_c_msb (w_c_msb)
`else
    .o_c_msb (w_unused_c_msb)
`endif
  );

  // Controller: capture operands in IDLE, add one chunk per RUN cycle, hold result in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_s     <= '0;
      r_c_out <= 1'b0;
`ifdef SEG_ADDER_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            // Subtraction is a + ~b + 1: invert b now, seed the carry with 1.
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub ? 1'b1 : c_in;
            r_idx   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_s[r_idx*W +: W] <= w_sum;
          r_carry           <= w_c;
          r_idx             <= r_idx + 1'b1;
          if (w_last) begin
            r_c_out <= w_c;
`ifdef SEG_ADDER_OVF_EN
            r_ovf   <= w_c_msb ^ w_c;
`endif
            r_state <= DONE;
          end
        end
        DONE: begin
          // The pop edge only returns to IDLE; the next accept is a cycle later.
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign s         = r_s;
  assign c_out     = r_c_out;
`ifdef SEG_ADDER_OVF_EN
  assign ovf       = r_ovf;
`else
  assign ovf       = 1'b0;
`endif

endmodule

// File: tb/tb_seg_adder.sv
// Directed bench for seg_adder: 32/8 instance for the main scenarios, 16/16 for the single-chunk case.
module tb_seg_adder;

`ifdef SEG_ADDER_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;

  logic        in_valid, in_ready, c_in, sub, out_valid, out_ready, c_out, ovf;
  logic [31:0] a, b, s;

  logic        k1_in_valid, k1_in_ready, k1_c_in, k1_sub, k1_out_valid, k1_out_ready, k1_c_out, k1_ovf;
  logic [15:0] k1_a, k1_b, k1_s;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seg_adder #(.N(32), .W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .s(s), .c_out(c_out), .ovf(ovf)
  );

  seg_adder #(.N(16), .W(16)) u_dut_k1 (
    .clk(clk), .rst_n(rst_n), .in_valid(k1_in_valid), .in_ready(k1_in_ready),
    .a(k1_a), .b(k1_b), .c_in(k1_c_in), .sub(k1_sub), .out_valid(k1_out_valid),
    .out_ready(k1_out_ready), .s(k1_s), .c_out(k1_c_out), .ovf(k1_ovf)
  );

  // Offer one operand set, then count edges until out_valid (-1 if it never comes).
  task automatic issue(input logic [31:0] ta, input logic [31:0] tb, input logic tcin,
                       input logic tsub, output int lat);
    @(negedge clk);
    a = ta; b = tb; c_in = tcin; sub = tsub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom; c_in = 1'b1; sub = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (out_valid !== 1'b1) lat = -1;
  endtask

  task automatic pop();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++; if ({s, c_out, ovf} !== 34'h0) begin n_fail++; $display("FAIL reset_outputs got s=%h c=%b o=%b want 0", s, c_out, ovf); end
    n_checks++; if (k1_out_valid !== 1'b0 || k1_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_k1 got ov=%b ir=%b want 0/1", k1_out_valid, k1_in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    int lat;
    issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, lat);
    n_checks++; if (lat != 4) begin n_fail++; $display("FAIL add_wrap_latency got %0d want 4", lat); end
    n_checks++; if ({s, c_out, ovf} !== {32'h0, 1'b1, 1'b0}) begin n_fail++; $display("FAIL add_wrap got s=%h c=%b o=%b want 00000000/1/0", s, c_out, ovf); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL add_done_in_ready got %b want 0", in_ready); end
    pop();
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL add_pop got ov=%b ir=%b want 0/1", out_valid, in_ready); end
    issue(32'h0000_0001, 32'h0000_0002, 1'b1, 1'b0, lat);
    n_checks++; if ({s, c_out, ovf} !== {32'h4, 1'b0, 1'b0}) begin n_fail++; $display("FAIL add_cin got s=%h c=%b o=%b want 00000004/0/0", s, c_out, ovf); end
    pop();
    issue(32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b0, lat);
    n_checks++; if ({s, c_out} !== {32'h0100_0100, 1'b0}) begin n_fail++; $display("FAIL add_chunk_carry got s=%h c=%b want 01000100/0", s, c_out); end
    pop();
  endtask

  task automatic test_sub();
    int lat;
    issue(32'd5, 32'd7, 1'b0, 1'b1, lat);
    n_checks++; if ({s, c_out, ovf} !== {32'hFFFF_FFFE, 1'b0, 1'b0}) begin n_fail++; $display("FAIL sub_5_7 got s=%h c=%b o=%b want fffffffe/0/0", s, c_out, ovf); end
    pop();
    // c_in must be ignored in subtract mode
    issue(32'd7, 32'd5, 1'b1, 1'b1, lat);
    n_checks++; if ({s, c_out, ovf} !== {32'h2, 1'b1, 1'b0}) begin n_fail++; $display("FAIL sub_7_5 got s=%h c=%b o=%b want 00000002/1/0", s, c_out, ovf); end
    pop();
  endtask

  task automatic test_ovf();
    int lat;
    issue(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, lat);
    n_checks++; if ({s, c_out, ovf} !== {32'h8000_0000, 1'b0, OVF_ON}) begin n_fail++; $display("FAIL ovf_add got s=%h c=%b o=%b want 80000000/0/%b", s, c_out, ovf, OVF_ON); end
    pop();
    issue(32'h8000_0000, 32'h1, 1'b0, 1'b1, lat);
    n_checks++; if ({s, c_out, ovf} !== {32'h7FFF_FFFF, 1'b1, OVF_ON}) begin n_fail++; $display("FAIL ovf_sub got s=%h c=%b o=%b want 7fffffff/1/%b", s, c_out, ovf, OVF_ON); end
    pop();
  endtask

  task automatic test_backpressure();
    int lat;
    int bad;
    issue(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, lat);
    n_checks++; if ({s, c_out} !== {32'h2345_6789, 1'b0}) begin n_fail++; $display("FAIL bp_result got s=%h c=%b want 23456789/0", s, c_out); end
    @(negedge clk);
    in_valid = 1'b1; a = 32'hAAAA_AAAA; b = 32'h5555_5555; out_ready = 1'b0;
    bad = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (s !== 32'h2345_6789 || c_out !== 1'b0 || ovf !== 1'b0 || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL bp_hold got %0d unstable cycles want 0", bad); end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release got ov=%b ir=%b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_back_to_back();
    logic        ov [0:10];
    logic        ir [0:10];
    logic [31:0] sv [0:10];
    @(negedge clk);
    a = 32'd1; b = 32'd2; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    for (int t = 1; t <= 10; t++) begin
      @(posedge clk); #1;
      ov[t] = out_valid; ir[t] = in_ready; sv[t] = s;
      if (t == 5) begin a = 32'd10; b = 32'd20; end
      if (t == 6) in_valid = 1'b0;
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++; if (ov[4] !== 1'b1 || sv[4] !== 32'd3) begin n_fail++; $display("FAIL b2b_first got ov=%b s=%h want 1/00000003", ov[4], sv[4]); end
    n_checks++; if (ov[5] !== 1'b0 || ir[5] !== 1'b1) begin n_fail++; $display("FAIL b2b_idle_gap got ov=%b ir=%b want 0/1", ov[5], ir[5]); end
    n_checks++; if (ir[6] !== 1'b0 || ov[9] !== 1'b0) begin n_fail++; $display("FAIL b2b_second_run got ir6=%b ov9=%b want 0/0", ir[6], ov[9]); end
    n_checks++; if (ov[10] !== 1'b1 || sv[10] !== 32'd30) begin n_fail++; $display("FAIL b2b_second got ov=%b s=%h want 1/0000001e", ov[10], sv[10]); end
  endtask

  task automatic test_reset_abort();
    int seen;
    @(negedge clk);
    a = 32'h0F0F_0F0F; b = 32'h0101_0101; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL abort_state got ov=%b ir=%b want 0/1", out_valid, in_ready); end
    n_checks++; if ({s, c_out, ovf} !== 34'h0) begin n_fail++; $display("FAIL abort_outputs got s=%h c=%b o=%b want 0", s, c_out, ovf); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) seen++;
    end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL abort_no_result got %0d busy cycles want 0", seen); end
  endtask

  task automatic test_k1();
    int lat;
    @(negedge clk);
    k1_a = 16'h8000; k1_b = 16'h8000; k1_c_in = 1'b0; k1_sub = 1'b0; k1_in_valid = 1'b1;
    @(posedge clk); #1;
    k1_in_valid = 1'b0;
    lat = 0;
    while (k1_out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (k1_out_valid !== 1'b1) lat = -1;
    n_checks++; if (lat != 1) begin n_fail++; $display("FAIL k1_latency got %0d want 1", lat); end
    n_checks++; if ({k1_s, k1_c_out, k1_ovf} !== {16'h0, 1'b1, OVF_ON}) begin n_fail++; $display("FAIL k1_result got s=%h c=%b o=%b want 0000/1/%b", k1_s, k1_c_out, k1_ovf, OVF_ON); end
    @(negedge clk);
    k1_out_ready = 1'b1;
    @(posedge clk); #1;
    k1_out_ready = 1'b0;
    n_checks++; if (k1_in_ready !== 1'b1) begin n_fail++; $display("FAIL k1_pop got ir=%b want 1", k1_in_ready); end
  endtask

  initial begin
    in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0; out_ready = 1'b0;
    k1_in_valid = 1'b0; k1_a = '0; k1_b = '0; k1_c_in = 1'b0; k1_sub = 1'b0; k1_out_ready = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_ovf();
    test_backpressure();
    test_back_to_back();
    test_reset_abort();
    test_k1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout after %0d checks", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
